// File: rtl/elastic_pkg.sv
// Shared sizing helpers for the elastic FIFO: pointer/count widths and the
// legality rule for the DEPTH parameter.
package elastic_pkg;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/elastic_fifo_mem.sv
// Storage array for elastic_fifo: one write port and one registered read port.
// Holds no reset; contents are only meaningful under the owner's count.
module elastic_fifo_mem
  import elastic_pkg::*;
#(
  parameter int DLEN  = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      we_i,
  input  logic [ptr_w(DEPTH)-1:0]   waddr_i,
  input  logic [DLEN-1:0]           wdata_i,
  input  logic [ptr_w(DEPTH)-1:0]   raddr_i,
  output logic [DLEN-1:0]           rdata_o
);

  logic [DLEN-1:0] mem_q [DEPTH];
  logic [DLEN-1:0] rdata_q;

  // Write port and registered read (read-during-write returns old data)
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/elastic_fifo.sv
// Elastic FIFO whose head word lives in a registered output stage; every
// output is a flop, so no input reaches an output combinationally.
module elastic_fifo
  import elastic_pkg::*;
#(
  parameter int DLEN  = 8,
  parameter int DEPTH = 4,
  parameter int AFULL = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_flush,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [DLEN-1:0]          i_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DLEN-1:0]          o_data,
  output logic [cnt_w(DEPTH)-1:0]  o_count,
  output logic                     o_afull
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL);

  if (!depth_ok(DEPTH) || (AFULL < 1) || (AFULL > DEPTH)) begin : g_param_err
    $error("elastic_fifo: DEPTH must be a power of 2 >= 2 and AFULL in 1..DEPTH");
  end

  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, raddr_s;
  logic [DLEN-1:0] data_q, data_d, rdata_s, byp_data_q, next_word_s;
  logic            valid_q, ready_q, afull_q, byp_sel_q;
  logic            push_s, pop_s, we_s, byp_hit_s;

  assign push_s = i_valid & ready_q;
  assign pop_s  = valid_q & i_ready;
  assign we_s   = push_s & ~i_flush;

  // The read port continuously prefetches the word behind the new head; a
  // write landing on that slot in the same edge is caught by the bypass.
  assign raddr_s     = rd_ptr_d + PW'(1);
  assign byp_hit_s   = we_s & (wr_ptr_q == raddr_s);
  assign next_word_s = byp_sel_q ? byp_data_q : rdata_s;

  // Next-state occupancy, pointers and head word
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    data_d   = data_q;
    if (i_flush) begin
      count_d  = CW'(0);
      rd_ptr_d = PW'(0);
      wr_ptr_d = PW'(0);
    end else begin
      count_d  = count_q + CW'(push_s) - CW'(pop_s);
      wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
      rd_ptr_d = pop_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
      if (push_s && ((count_q == CW'(0)) || (pop_s && (count_q == CW'(1))))) begin
        data_d = i_data;
      end else if (pop_s && (count_q >= CW'(2))) begin
        data_d = next_word_s;
      end else begin
        data_d = data_q;
      end
    end
  end

  // State and registered status outputs, all derived from the post-edge count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q    <= CW'(0);
      rd_ptr_q   <= PW'(0);
      wr_ptr_q   <= PW'(0);
      data_q     <= {DLEN{1'b0}};
      valid_q    <= 1'b0;
      ready_q    <= 1'b0;
      afull_q    <= 1'b0;
      byp_sel_q  <= 1'b0;
      byp_data_q <= {DLEN{1'b0}};
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      data_q     <= data_d;
      valid_q    <= (count_d != CW'(0));
      ready_q    <= (count_d < DEPTH_C);
      afull_q    <= (count_d >= AFULL_C);
      byp_sel_q  <= byp_hit_s;
      byp_data_q <= i_data;
    end
  end

  elastic_fifo_mem #(
    .DLEN  (DLEN),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (we_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (i_data),
    .raddr_i (raddr_s),
    .rdata_o (rdata_s)
  );

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_count = count_q;
  assign o_afull = afull_q;

endmodule

// File: tb/tb_elastic_fifo.sv
// Scenario bench for elastic_fifo (DLEN=8, DEPTH=4, AFULL=3) with an
// arrival-order scoreboard checked on every accepted pop.
module tb_elastic_fifo;

  localparam int DLEN  = 8;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;
  localparam int CW    = 3;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            i_flush = 1'b0;
  logic            i_valid = 1'b0;
  logic            i_ready = 1'b0;
  logic [DLEN-1:0] i_data = '0;
  logic            o_ready, o_valid, o_afull;
  logic [DLEN-1:0] o_data;
  logic [CW-1:0]   o_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  logic [DLEN-1:0] sb [$];

  elastic_fifo #(.DLEN(DLEN), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_count (o_count),
    .o_afull (o_afull)
  );

  always #5 clk = ~clk;

  // Called at a falling edge with inputs already set: records what the DUT
  // will accept at the next rising edge, then advances to the next falling edge.
  task automatic step();
    bit push, pop;
    logic [DLEN-1:0] exp;
    push = i_valid && o_ready && !i_flush;
    pop  = o_valid && i_ready && !i_flush;
    if (i_flush) begin
      sb.delete();
    end else begin
      if (pop) begin
        n_checks++;
        n_pops++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_pop: got unexpected word %02h, want none", o_data);
        end else begin
          exp = sb.pop_front();
          if (o_data !== exp) begin
            n_fail++;
            $display("FAIL sb_pop: got %02h want %02h", o_data, exp);
          end
        end
      end
      if (push) sb.push_back(i_data);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({o_valid, o_ready, o_afull, o_count, o_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b r=%0b af=%0b c=%0d d=%02h want all 0",
               o_valid, o_ready, o_afull, o_count, o_data);
    end
    rstn = 1'b1;
    step();
    n_checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got r=%0b v=%0b want r=1 v=0", o_ready, o_valid);
    end
  endtask

  task automatic test_single();
    i_valid = 1'b1; i_data = 8'h11; i_ready = 1'b0;
    step();
    i_valid = 1'b0;
    n_checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h11 || o_count !== 3'd1) begin
      n_fail++;
      $display("FAIL single_latency: got v=%0b d=%02h c=%0d want v=1 d=11 c=1",
               o_valid, o_data, o_count);
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0 || o_count !== 3'd0) begin
      n_fail++;
      $display("FAIL single_drain: got v=%0b c=%0d want v=0 c=0", o_valid, o_count);
    end
  endtask

  task automatic test_fill();
    int ec;
    i_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      i_valid = 1'b1;
      i_data  = 8'(v);
      n_checks++;
      if (o_ready !== ((v <= 4) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL fill_ready_pre%0d: got %0b want %0b", v, o_ready, (v <= 4));
      end
      step();
      ec = (v > 4) ? 4 : v;
      n_checks++;
      if (o_count !== CW'(ec) || o_afull !== (ec >= AFULL) || o_ready !== (ec < DEPTH)) begin
        n_fail++;
        $display("FAIL fill_status%0d: got c=%0d af=%0b r=%0b want c=%0d af=%0b r=%0b",
                 v, o_count, o_afull, o_ready, ec, (ec >= AFULL), (ec < DEPTH));
      end
    end
    n_checks++;
    if (o_data !== 8'h01) begin
      n_fail++;
      $display("FAIL fill_head: got %02h want 01", o_data);
    end
  endtask

  task automatic test_full_pop();
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    n_checks++;
    if (o_ready !== 1'b1 || o_count !== 3'd3 || o_data !== 8'h02) begin
      n_fail++;
      $display("FAIL fullpop_after: got r=%0b c=%0d d=%02h want r=1 c=3 d=02",
               o_ready, o_count, o_data);
    end
    step();
    i_valid = 1'b0;
    n_checks++;
    if (o_count !== 3'd4 || o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fullpop_accept05: got c=%0d r=%0b want c=4 r=0", o_count, o_ready);
    end
    i_ready = 1'b1;
    repeat (4) step();
    i_ready = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0 || o_count !== 3'd0) begin
      n_fail++;
      $display("FAIL fullpop_drain: got v=%0b c=%0d want v=0 c=0", o_valid, o_count);
    end
  endtask

  task automatic test_back_to_back();
    int k, cyc, pops0;
    k = 0; cyc = 0; pops0 = n_pops;
    i_valid = 1'b1; i_ready = 1'b1;
    while (k < 256 && cyc < 300) begin
      i_data = 8'(k);
      if (cyc > 0) begin
        n_checks++;
        if (o_count !== 3'd1 || o_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_steady%0d: got c=%0d r=%0b want c=1 r=1", cyc, o_count, o_ready);
        end
      end
      if (o_ready) k++;
      step();
      cyc++;
    end
    i_valid = 1'b0;
    for (int d = 0; d < 8 && o_valid; d++) step();
    i_ready = 1'b0;
    n_checks++;
    if (cyc !== 256 || (n_pops - pops0) !== 256) begin
      n_fail++;
      $display("FAIL b2b_throughput: got cycles=%0d pops=%0d want 256 256", cyc, n_pops - pops0);
    end
  endtask

  task automatic test_flush();
    i_ready = 1'b0;
    for (int v = 0; v < 3; v++) begin
      i_valid = 1'b1; i_data = 8'h21 + 8'(v);
      step();
    end
    n_checks++;
    if (o_count !== 3'd3 || o_afull !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pre: got c=%0d af=%0b want c=3 af=1", o_count, o_afull);
    end
    i_flush = 1'b1; i_data = 8'h99;
    step();
    i_flush = 1'b0; i_valid = 1'b0;
    n_checks++;
    if (o_count !== 3'd0 || o_valid !== 1'b0 || o_ready !== 1'b1 || o_afull !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_state: got c=%0d v=%0b r=%0b af=%0b want 0 0 1 0",
               o_count, o_valid, o_ready, o_afull);
    end
    i_valid = 1'b1; i_data = 8'hAA;
    step();
    i_valid = 1'b0;
    n_checks++;
    if (o_valid !== 1'b1 || o_data !== 8'hAA || o_count !== 3'd1) begin
      n_fail++;
      $display("FAIL flush_first: got v=%0b d=%02h c=%0d want 1 AA 1", o_valid, o_data, o_count);
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0;
    i_valid = 1'b1; i_data = 8'h31; step();
    i_data = 8'h32; step();
    n_checks++;
    if (o_count !== 3'd2) begin
      n_fail++;
      $display("FAIL rstmid_pre: got c=%0d want 2", o_count);
    end
    rstn = 1'b0;
    #1;
    sb.delete();
    n_checks++;
    if ({o_valid, o_ready, o_afull, o_count, o_data} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: got v=%0b r=%0b af=%0b c=%0d d=%02h want all 0",
               o_valid, o_ready, o_afull, o_count, o_data);
    end
    i_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    step();
    step();
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_count !== 3'd0) begin
      n_fail++;
      $display("FAIL rstmid_release: got v=%0b r=%0b c=%0d want 0 1 0", o_valid, o_ready, o_count);
    end
    i_valid = 1'b1; i_data = 8'h44;
    step();
    i_valid = 1'b0;
    n_checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h44) begin
      n_fail++;
      $display("FAIL rstmid_newpush: got v=%0b d=%02h want 1 44", o_valid, o_data);
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
  endtask

  task automatic test_random();
    int sz;
    for (int c = 0; c < 300; c++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_ready = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
      if (c >= 150) i_ready = 1'($urandom_range(0, 1));
      i_data  = 8'($urandom);
      sz = sb.size();
      n_checks++;
      if (o_count !== CW'(sz) || o_valid !== (sz != 0) || o_ready !== (sz < DEPTH) ||
          o_afull !== (sz >= AFULL)) begin
        n_fail++;
        $display("FAIL rand_status%0d: got c=%0d v=%0b r=%0b af=%0b want c=%0d", c,
                 o_count, o_valid, o_ready, o_afull, sz);
      end
      step();
    end
    i_valid = 1'b0; i_ready = 1'b1;
    for (int d = 0; d < 8 && o_valid; d++) step();
    i_ready = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain: got v=%0b left=%0d want v=0 left=0", o_valid, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elastic_fifo.md
ELASTIC_FIFO -- requirements
Module: elastic_fifo

Interface
REQ-001 SHALL have parameter DLEN, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, total word capacity including output register (power of 2, >=2).
REQ-003 SHALL have parameter AFULL, default DEPTH-1, occupancy at or above which o_afull asserts (1..DEPTH).
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_flush  input  1  synchronous clear of all stored words.
REQ-007 SHALL have port i_valid  input  1  upstream word valid.
REQ-008 SHALL have port o_ready  output  1  registered; space available for upstream.
REQ-009 SHALL have port i_data  input  DLEN  upstream word.
REQ-010 SHALL have port o_valid  output  1  registered; downstream word valid.
REQ-011 SHALL have port i_ready  input  1  downstream accepts word.
REQ-012 SHALL have port o_data  output  DLEN  registered downstream word.
REQ-013 SHALL have port o_count  output  $clog2(DEPTH+1)  registered occupancy.
REQ-014 SHALL have port o_afull  output  1  registered; o_count >= AFULL.

Function
REQ-015 SHALL define push = i_valid & o_ready and pop = o_valid & i_ready, both sampled at the rising clk edge.
REQ-016 SHALL store words strictly in arrival order; no drop, no duplication.
REQ-017 SHALL have no combinational path from any input to any output.
REQ-018 SHALL present a word pushed into an empty FIFO on o_valid/o_data in the cycle after the push (latency 1).
REQ-019 SHALL sustain one push and one pop per cycle indefinitely when 0 < count < DEPTH.
REQ-020 SHALL hold o_data and o_valid stable while o_valid=1 and i_ready=0.
REQ-021 SHALL update count to count + push - pop each cycle; o_count, o_afull and o_ready reflect the post-edge count.
REQ-022 SHALL drive o_ready = (next count < DEPTH); when full, a same-cycle pop raises o_ready next cycle, and i_valid in the full cycle is not accepted.
REQ-023 SHALL, on push and pop at count=1, load the pushed word into o_data with o_valid remaining 1 and count remaining 1.
REQ-024 SHALL, on a pop at count=1 without push, deassert o_valid next cycle.
REQ-025 SHALL wrap read/write pointers modulo DEPTH without affecting order.
REQ-026 SHALL, when i_flush=1, set count=0, o_valid=0, o_ready=1, o_afull=0 next cycle; a push or pop in the flush cycle is discarded.
REQ-027 SHALL leave o_data value undefined-but-stable after flush (not required to clear).

Reset
REQ-028 SHALL, while rstn=0, force o_valid=0, o_ready=0, o_count=0, o_afull=0, o_data=0, pointers=0, asynchronously.
REQ-029 SHALL raise o_ready on the first rising clk edge after rstn deasserts.
REQ-030 SHALL discard all contents on reset asserted mid-transfer; storage array itself needs no reset.

Structure
REQ-031 SHALL place the pointer/count width helper functions and a DEPTH-legality check in shared package elastic_pkg.
REQ-032 SHALL implement storage as sub-module elastic_fifo_mem (DEPTH x DLEN, one write port, one registered read port, no reset).
REQ-033 SHALL be 120-400 lines of RTL total.

Verification (DLEN=8, DEPTH=4, AFULL=3)
REQ-034 SHALL check: reset release, push 0x11 -> o_valid=1, o_data=0x11 one cycle later, o_count=1.
REQ-035 SHALL check: push 0x01..0x04 with i_ready=0 -> o_count=4, o_ready=0, o_afull=1 from count 3; 0x05 held and not accepted.
REQ-036 SHALL check: full, then i_ready=1 for 1 cycle -> 0x01 popped, o_ready=1 next cycle, 0x05 then accepted, order 0x02..0x05 preserved.
REQ-037 SHALL check: continuous push/pop of 0x00..0xFF -> one word per cycle, output sequence equals input, pointers wrap.
REQ-038 SHALL check: i_flush with count=3 plus simultaneous push -> count=0, o_valid=0, o_ready=1; next push 0xAA emerges first.
REQ-039 SHALL check: rstn asserted mid-stream at count=2 -> outputs zero immediately; after release o_valid=0 until new push.
